alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 149 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execution unit with a valid/ready request/response handshake.
// Single-cycle ALU operations and an optional iterative shift-add multiply.
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready.
// A result transfers on a rising edge where out_valid & out_ready. The result
// registers and out_valid hold while out_valid & !out_ready.
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             IllegalOp,
    output logic             state_dbg
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] dec_res;
    logic             dec_ill;
    logic             dec_mul;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [SHW-1:0]   cnt;

    logic             accept;
    logic             mul_done;

    assign shamt     = SrcA[SHW-1:0];
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_done  = (state == MUL) && (cnt == SHW'(WIDTH - 1));
    assign acc_next  = acc + (mplier[0] ? mcand : '0);
    assign state_dbg = (state == MUL);

    // Operation decode and single-cycle result computation.
    always_comb begin
        dec_res = '0;
        dec_ill = 1'b0;
        dec_mul = 1'b0;
        case (ALUOp)
            2'b00: dec_res = SrcA + SrcB;
            2'b01: dec_res = SrcA - SrcB;
            2'b11: dec_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: begin
                case (Funct)
                    6'b100000: dec_res = SrcA + SrcB;
                    6'b100010: dec_res = SrcA - SrcB;
                    6'b100100: dec_res = SrcA & SrcB;
                    6'b100101: dec_res = SrcA | SrcB;
                    6'b100110: dec_res = SrcA ^ SrcB;
                    6'b100111: dec_res = ~(SrcA | SrcB);
                    6'b101010: dec_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
                    6'b101011: dec_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
                    6'b000100: dec_res = SrcB << shamt;
                    6'b000110: dec_res = SrcB >> shamt;
                    6'b000111: dec_res = $signed(SrcB) >>> shamt;
                    6'b011000: begin
                        // Without the multiplier the opcode is reported illegal.
                        if (MUL_EN) dec_mul = 1'b1;
                        else        dec_ill = 1'b1;
                    end
                    default:   dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: enter MUL on an accepted multiply, leave after the last iteration.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && dec_mul) state_next = MUL;
            MUL:     if (mul_done)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift-add multiplier: operands latched at acceptance, one multiplier bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && dec_mul) begin
            mcand  <= SrcA;
            mplier <= SrcB;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + SHW'(1);
        end
    end

    // Result register: load on single-cycle accept or multiply completion, else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            IllegalOp <= 1'b0;
        end else if (accept && !dec_mul) begin
            out_valid <= 1'b1;
            ALUResult <= dec_res;
            Zero      <= (dec_res == '0);
            IllegalOp <= dec_ill;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            ALUResult <= acc_next;
            Zero      <= (acc_next == '0);
            IllegalOp <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops, plus
// hand-written sequences for multiply latency, backpressure and reset abort.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   ALUOp;
    logic [5:0]   Funct;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         Zero;
    logic         IllegalOp;
    logic         state_dbg;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .Funct     (Funct),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .IllegalOp (IllegalOp),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        ALUOp    = op;
        Funct    = fn;
        SrcA     = a;
        SrcB     = b;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 6'b111111, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0};
        vecs[1]  = '{2'b01, 6'b000000, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{2'b11, 6'b000000, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0};
        vecs[3]  = '{2'b10, 6'b100010, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4]  = '{2'b10, 6'b101010, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0};
        vecs[5]  = '{2'b10, 6'b101011, 32'h80000000, 32'd1,        32'd0,        1'b1, 1'b0};
        vecs[6]  = '{2'b10, 6'b000111, 32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 6'b000110, 32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 6'b000100, 32'd4,        32'd1,        32'h00000010, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 6'b100101, 32'h0000F0F0, 32'h00000F00, 32'h0000FFF0, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 6'b100110, 32'h000000FF, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 6'b100111, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[13] = '{2'b10, 6'b100000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
        vecs[14] = '{2'b10, 6'b111111, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1};
        vecs[15] = '{2'b10, 6'b000111, 32'd33,       32'h80000000, 32'hC0000000, 1'b0, 1'b0};
        vecs[16] = '{2'b10, 6'b101011, 32'd1,        32'h80000000, 32'd1,        1'b0, 1'b0};
        vecs[17] = '{2'b10, 6'b000001, 32'd1,        32'd1,        32'd0,        1'b1, 1'b1};

        // Reset state
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUOp     = 2'b00;
        Funct     = 6'b000000;
        SrcA      = '0;
        SrcB      = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(ALUResult), 64'd0);
        chk("rst_zero",      64'(Zero),      64'd1);
        chk("rst_illegal",   64'(IllegalOp), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        tick();

        // Single-cycle vectors, latency one
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i),   64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_result", i),  64'(ALUResult), 64'(vecs[i].res));
            chk($sformatf("vec%0d_zero", i),    64'(Zero),      64'(vecs[i].zero));
            chk($sformatf("vec%0d_illegal", i), 64'(IllegalOp), 64'(vecs[i].ill));
            tick();
            chk($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
        end

        // Multiply: result exactly WIDTH cycles after acceptance, inputs ignored meanwhile
        drive(2'b10, 6'b011000, 32'h00010001, 32'h00010001);
        tick();
        drive(2'b10, 6'b100000, 32'h12345678, 32'h11111111);
        chk("mul_accept_busy", 64'(in_ready),  64'd0);
        chk("mul_accept_nov",  64'(out_valid), 64'd0);
        for (int j = 1; j < W; j++) begin
            tick();
            chk($sformatf("mul_c%0d_valid", j), 64'(out_valid), 64'd0);
            chk($sformatf("mul_c%0d_ready", j), 64'(in_ready),  64'd0);
        end
        tick();
        in_valid = 1'b0;
        chk("mul_done_valid",   64'(out_valid), 64'd1);
        chk("mul_done_result",  64'(ALUResult), 64'h00020001);
        chk("mul_done_zero",    64'(Zero),      64'd0);
        chk("mul_done_illegal", 64'(IllegalOp), 64'd0);
        tick();
        chk("mul_drained", 64'(out_valid), 64'd0);

        drive(2'b10, 6'b011000, 32'hFFFFFFFF, 32'd3);
        tick();
        in_valid = 1'b0;
        repeat (W - 1) tick();
        chk("mul2_early", 64'(out_valid), 64'd0);
        tick();
        chk("mul2_valid",  64'(out_valid), 64'd1);
        chk("mul2_result", 64'(ALUResult), 64'hFFFFFFFD);
        tick();

        // Backpressure: result held while out_ready low, queued add waits
        out_ready = 1'b0;
        drive(2'b00, 6'b000000, 32'd3, 32'd4);
        tick();
        drive(2'b00, 6'b000000, 32'd10, 32'd20);
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("stall%0d_valid", j),  64'(out_valid), 64'd1);
            chk($sformatf("stall%0d_result", j), 64'(ALUResult), 64'd7);
            chk($sformatf("stall%0d_ready", j),  64'(in_ready),  64'd0);
            tick();
        end
        out_ready = 1'b1;
        exp_q.push_back(32'd30);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk($sformatf("b2b%0d_valid", j),  64'(out_valid), 64'd1);
            chk($sformatf("b2b%0d_result", j), 64'(ALUResult), 64'(exp_q.pop_front()));
            drive(2'b00, 6'b000000, 32'(j), 32'd100);
            exp_q.push_back(32'(100 + j));
        end
        tick();
        in_valid = 1'b0;
        chk("b2b_last_valid",  64'(out_valid), 64'd1);
        chk("b2b_last_result", 64'(ALUResult), 64'(exp_q.pop_front()));
        tick();
        chk("b2b_no_dup", 64'(out_valid), 64'd0);
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-multiply aborts it; first edge after release accepts
        drive(2'b10, 6'b011000, 32'd7, 32'd9);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #2;
        chk("arst_valid",  64'(out_valid), 64'd0);
        chk("arst_result", 64'(ALUResult), 64'd0);
        chk("arst_zero",   64'(Zero),      64'd1);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 64'(in_ready),  64'd1);
        chk("rel_valid", 64'(out_valid), 64'd0);
        drive(2'b00, 6'b000000, 32'd1, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("rel_first_valid",  64'(out_valid), 64'd1);
        chk("rel_first_result", 64'(ALUResult), 64'd2);
        tick();
        begin
            int spurious;
            spurious = 0;
            for (int j = 0; j < 2 * W; j++) begin
                if (out_valid || !in_ready) spurious++;
                tick();
            end
            chk("abort_no_result", 64'(spurious), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
